// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
// Owner and FSM state encodings live here so the top and the priority picker agree on them.
package zp_mem_pkg;

   localparam int XLEN     = 32;
   localparam int MEM_BE_W = 4;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RESP
   } arb_state_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Owner selection between fetch and data requests, with the data-streak counter
// that forces a fetch grant after MAX_D_STREAK back-to-back data grants.
module mem_arb_prio
   import zp_mem_pkg::*;
#(
   parameter int MAX_D_STREAK = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   arb_en,
   input  logic   i_req,
   input  logic   d_req,
   output logic   grant_valid,
   output owner_e grant_owner
);

   localparam int             SW         = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);

   logic [SW-1:0] streak;

   // Data wins unless fetch is also waiting and data has used up its streak.
   always_comb begin
      grant_valid = i_req | d_req;
      grant_owner = OWN_I;
      if (d_req && !(i_req && (streak == STREAK_MAX))) begin
         grant_owner = OWN_D;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         streak <= '0;
      end else if (arb_en && grant_valid) begin
         if (grant_owner == OWN_I || !i_req) begin
            streak <= '0;
         end else if (streak != STREAK_MAX) begin
            streak <= streak + SW'(1);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and the data stage: one access at a time,
// sequenced request -> grant -> response, with per-port done pulses and a hang timeout.
module mem_port_arbiter
   import zp_mem_pkg::*;
#(
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [XLEN-1:0]     i_addr,
   output logic [XLEN-1:0]     i_rdata,
   output logic                i_done,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [MEM_BE_W-1:0] d_be,
   input  logic [XLEN-1:0]     d_addr,
   input  logic [XLEN-1:0]     d_wdata,
   output logic [XLEN-1:0]     d_rdata,
   output logic                d_done,
   output logic                err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [MEM_BE_W-1:0] mem_be,
   output logic [XLEN-1:0]     mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   arb_state_e          state;
   arb_state_e          state_nxt;
   owner_e              owner;
   owner_e              grant_owner;
   logic                grant_valid;
   logic                lat_we;
   logic [MEM_BE_W-1:0] lat_be;
   logic [XLEN-1:0]     lat_addr;
   logic [XLEN-1:0]     lat_wdata;
   logic [TW-1:0]       tmo_cnt;
   logic                resp_done;
   logic                tmo_hit;

   mem_arb_prio #(
      .MAX_D_STREAK(MAX_D_STREAK)
   ) u_prio (
      .clk        (clk),
      .reset      (reset),
      .arb_en     (state == IDLE),
      .i_req      (i_req),
      .d_req      (d_req),
      .grant_valid(grant_valid),
      .grant_owner(grant_owner)
   );

   // A real response beats a timeout that lands in the same cycle.
   assign resp_done = (state == WAIT_RESP) && mem_rvalid;
   assign tmo_hit   = (state != IDLE) && (tmo_cnt == TMO_LAST) && !resp_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (grant_valid) state_nxt = WAIT_GNT;
         WAIT_GNT:  if (tmo_hit) state_nxt = IDLE;
                    else if (mem_gnt) state_nxt = WAIT_RESP;
         WAIT_RESP: if (resp_done || tmo_hit) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Outputs are masked during reset so an in-flight response cannot leak a done.
   always_comb begin
      mem_req   = !reset && (state == WAIT_GNT) && !tmo_hit;
      mem_we    = lat_we;
      mem_be    = lat_be;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      i_done    = !reset && (resp_done || tmo_hit) && (owner == OWN_I);
      d_done    = !reset && (resp_done || tmo_hit) && (owner == OWN_D);
      err       = !reset && tmo_hit;
      i_rdata   = (!reset && resp_done && owner == OWN_I) ? mem_rdata : '0;
      d_rdata   = (!reset && resp_done && owner == OWN_D) ? mem_rdata : '0;
   end

   // Fields are captured at the grant so requester changes mid-access cannot reach memory.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner     <= OWN_I;
         lat_we    <= 1'b0;
         lat_be    <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (state == IDLE && grant_valid) begin
         owner <= grant_owner;
         if (grant_owner == OWN_D) begin
            lat_we    <= d_we;
            lat_be    <= d_be;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
         end else begin
            lat_we    <= 1'b0;
            lat_be    <= '1;
            lat_addr  <= i_addr;
            lat_wdata <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || state == IDLE) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction read) and the data-memory stage (load/store).
- Sits between the pipeline stages and the memory. Sequences each access through request, grant and response.
- Gives per-requester done pulses so the pipeline can derive stalls.
- Data has priority; a streak counter prevents fetch starvation; a timeout recovers from a hung memory.

Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while fetch is waiting before fetch is forced.
- TIMEOUT, 64: cycles from entering WAIT_GNT to forced completion with error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request; held until i_done
- i_addr  in  32  fetch address
- i_rdata  out  32  instruction data; valid with i_done
- i_done  out  1  one-cycle completion pulse to fetch
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; valid with d_done
- d_done  out  1  one-cycle completion pulse to data stage
- err  out  1  pulses with done when the access timed out
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  response/ack; reads and writes both get one
- mem_rdata  in  32  memory read data

Behaviour:
- FSM states: IDLE, WAIT_GNT, WAIT_RESP. At most one access outstanding.
- Reset: state IDLE; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0.
- Reset also clears i_done, d_done and err to 0, the streak counter to 0, and the timeout counter to 0.
- Reset mid-access abandons the access and emits no done. A late mem_rvalid after reset is ignored.
- IDLE arbitration (registered decision):
  - Only d_req: grant data.
  - Only i_req: grant instruction.
  - Both: grant data unless streak==MAX_D_STREAK, in which case grant instruction.
  - On a grant, latch owner, we, be, addr and wdata. Instruction grants drive we=0 and be=4'hF. Go to WAIT_GNT.
- Streak counter:
  - Increments on each data grant made while i_req=1.
  - Clears on any instruction grant.
  - Clears on a data grant made while i_req=0.
  - Saturates at MAX_D_STREAK.
- WAIT_GNT: mem_req=1 and mem_* are driven from the latched fields. When mem_gnt=1, go to WAIT_RESP with mem_req=0 the next cycle.
- WAIT_RESP: on mem_rvalid, the owner's done=1 in the same cycle. Owner rdata = mem_rdata (combinational pass-through); the other port's rdata=0. Go to IDLE.
- mem_rvalid in the same cycle as mem_gnt is not legal memory behaviour. mem_rvalid in IDLE or WAIT_GNT is ignored.
- Minimum latency: req sampled at cycle 0 → mem_req at cycle 1 → gnt at cycle 1 → rvalid/done at cycle 2 → next arbitration at cycle 3.
- Timeout:
  - Counter runs while in WAIT_GNT or WAIT_RESP.
  - If it reaches TIMEOUT-1 without completion: the owner's done=1, err=1, owner rdata=0, mem_req=0, go to IDLE.
  - A late rvalid for the timed-out access arriving in IDLE is ignored.
- Stall derivation (for the pipeline, not in this block): i_stall = i_req & ~i_done; d_stall = d_req & ~d_done.
- Requesters keep their request fields stable from req rise until done. The arbiter's own outputs are always driven from latched copies regardless.

Decomposition:
- Package zp_mem_pkg holds:
  - owner_e {OWN_I, OWN_D}
  - arb_state_e {IDLE, WAIT_GNT, WAIT_RESP}
  - constant MEM_BE_W = 4
  - constant XLEN = 32
- One sub-module, mem_arb_prio: combinational owner pick from i_req, d_req and the streak count, plus the registered streak counter.

Test Plan:
- d_req load @0x100, gnt at cycle 1, rvalid=0xDEADBEEF at cycle 2 → d_done and d_rdata=0xDEADBEEF at cycle 2; i_done=0; err=0.
- i_req and d_req asserted together → data served first; instruction granted at the next IDLE (cycle 3); mem_we=0 and mem_be=4'hF on the instruction access.
- i_req held high while d_req is re-asserted after each d_done; MAX_D_STREAK=4 → exactly 4 data accesses, then one instruction access, then the streak restarts at 0.
- Store d_be=4'b0011, d_wdata=0x12345678, gnt delayed 5 cycles → mem_req held high for 6 cycles with stable fields; d_done on the ack.
- TIMEOUT=8, no gnt → d_done=1, err=1 and d_rdata=0 exactly 8 cycles after entering WAIT_GNT; a subsequent stray rvalid in IDLE produces no done.
- reset asserted in WAIT_RESP → next cycle IDLE with mem_req=0; the pending rvalid is ignored; i_done=0 and d_done=0.
